// File: rtl/trojan_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : trojan_pkg                                                      |
// | Brief    : Shared state encoding, default trigger word and width helpers.  |
// | Revision : 1.0                                                             |
// +----------------------------------------------------------------------------+
package trojan_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ARM  = 2'd1,
        ST_LEAK = 2'd2,
        ST_DONE = 2'd3
    } state_t;

    localparam logic [63:0] TRIG_VAL_DEFAULT = 64'h0000_0000_0044_ab93;

    // A single-slot bus still needs a 1-bit select so port widths stay legal.
    function automatic int sel_width(input int data_w, input int nib_w);
        int slots;
        slots = data_w / nib_w;
        return (slots > 1) ? $clog2(slots) : 1;
    endfunction

    function automatic int leak_cycles(input int nib_w, input int captures, input int shift_w);
        return (nib_w * captures) / shift_w;
    endfunction

    function automatic int ctr_width(input int max_count);
        return $clog2(max_count + 1);
    endfunction

endpackage
`default_nettype wire

// File: rtl/trojan_slice_sel.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : trojan_slice_sel                                                |
// | Brief    : Slot mux picking one NIB_W slice of the bus, clamped to top.    |
// | Revision : 1.0                                                             |
// +----------------------------------------------------------------------------+
module trojan_slice_sel
    import trojan_pkg::*;
#(
    parameter int DATA_W = 64,
    parameter int NIB_W  = 4,
    localparam int SEL_W = sel_width(DATA_W, NIB_W)
) (
    input  logic [DATA_W-1:0] data,
    input  logic [SEL_W-1:0]  sel,
    output logic [NIB_W-1:0]  slice
);

    localparam int               C_SLOTS = DATA_W / NIB_W;
    localparam logic [SEL_W-1:0] C_TOP   = SEL_W'(C_SLOTS - 1);

    logic [SEL_W-1:0] w_sel_clamped;

    // Select codes past the last whole slot fall back to the top slot.
    assign w_sel_clamped = (sel > C_TOP) ? C_TOP : sel;

    always_comb begin
        slice = '0;
        for (int i = 0; i < C_SLOTS; i++) begin
            if (w_sel_clamped == SEL_W'(i)) begin
                slice = data[i*NIB_W +: NIB_W];
            end
        end
    end

    if ((DATA_W % NIB_W) != 0) begin : g_spare_bits
        logic w_spare_unused;
        assign w_spare_unused = ^data[DATA_W-1:C_SLOTS*NIB_W];
    end

endmodule
`default_nettype wire

// File: rtl/trojan_leak_param.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : trojan_leak_param                                               |
// | Brief    : Trigger-armed slice capture, serialised SHIFT_W bits per cycle. |
// | Revision : 1.0                                                             |
// +----------------------------------------------------------------------------+
module trojan_leak_param
    import trojan_pkg::*;
#(
    parameter int          DATA_W   = 64,
    parameter int          NIB_W    = 4,
    parameter int          CAPTURES = 4,
    parameter int          SHIFT_W  = 2,
    parameter int          TRIG_W   = 64,
    parameter logic [63:0] TRIG_VAL = TRIG_VAL_DEFAULT,
    parameter bit          ONE_SHOT = 1'b0
) (
    input  logic               clk,
    input  logic               rst_all_n,
    input  logic [DATA_W-1:0]  data,
    output logic [SHIFT_W-1:0] leak_bits,
    output logic               leak_valid,
    output logic               busy
);

    localparam int C_SEL_W      = sel_width(DATA_W, NIB_W);
    localparam int C_CAP_BITS   = NIB_W * CAPTURES;
    localparam int C_LEAK_CYC   = leak_cycles(NIB_W, CAPTURES, SHIFT_W);
    localparam int C_CAP_CTR_W  = ctr_width(CAPTURES);
    localparam int C_LEAK_CTR_W = ctr_width(C_LEAK_CYC);

    localparam logic [C_CAP_CTR_W-1:0]  C_CAP_LAST  = C_CAP_CTR_W'(CAPTURES - 1);
    localparam logic [C_LEAK_CTR_W-1:0] C_LEAK_LAST = C_LEAK_CTR_W'(C_LEAK_CYC - 1);

    if ((C_CAP_BITS % SHIFT_W) != 0) begin : g_bad_shift
        $error("trojan_leak_param: NIB_W*CAPTURES must be a multiple of SHIFT_W");
    end
    if ((TRIG_W > DATA_W) || (TRIG_W > 64)) begin : g_bad_trig
        $error("trojan_leak_param: TRIG_W exceeds bus or trigger width");
    end

    state_t                   r_state;
    logic [C_SEL_W-1:0]       r_data_q;
    logic [C_SEL_W-1:0]       r_sel;
    logic [C_CAP_CTR_W-1:0]   r_cap_ctr;
    logic [C_LEAK_CTR_W-1:0]  r_leak_ctr;
    logic [C_CAP_BITS-1:0]    r_cap;
    logic [SHIFT_W-1:0]       r_leak_bits;
    logic                     r_leak_valid;
    logic                     r_busy;

    logic [NIB_W-1:0]         w_slice;
    logic                     w_trig;
    logic [C_CAP_BITS-1:0]    w_cap_fill;
    logic [C_CAP_BITS-1:0]    w_cap_shift;

    trojan_slice_sel #(
        .DATA_W (DATA_W),
        .NIB_W  (NIB_W)
    ) u_slice_sel (
        .data   (data),
        .sel    (r_sel),
        .slice  (w_slice)
    );

    assign w_trig      = (data[TRIG_W-1:0] == TRIG_VAL[TRIG_W-1:0]);
    assign w_cap_shift = r_cap >> SHIFT_W;

    for (genvar gi = 0; gi < CAPTURES; gi++) begin : g_slot
        assign w_cap_fill[gi*NIB_W +: NIB_W] =
            (r_cap_ctr == C_CAP_CTR_W'(gi)) ? w_slice : r_cap[gi*NIB_W +: NIB_W];
    end

    // Output flops are loaded one edge ahead from the next capture value so the
    // first leak beat appears in the cycle right after the last capture edge.
    always_ff @(posedge clk or negedge rst_all_n) begin
        if (!rst_all_n) begin
            r_state      <= ST_IDLE;
            r_data_q     <= '0;
            r_sel        <= '0;
            r_cap_ctr    <= '0;
            r_leak_ctr   <= '0;
            r_cap        <= '0;
            r_leak_bits  <= '0;
            r_leak_valid <= 1'b0;
            r_busy       <= 1'b0;
        end else begin
            r_data_q <= data[C_SEL_W-1:0];
            case (r_state)
                ST_IDLE: begin
                    if (w_trig) begin
                        r_sel     <= r_data_q;
                        r_cap_ctr <= '0;
                        r_state   <= ST_ARM;
                        r_busy    <= 1'b1;
                    end
                end
                ST_ARM: begin
                    r_cap <= w_cap_fill;
                    if (r_cap_ctr == C_CAP_LAST) begin
                        r_state      <= ST_LEAK;
                        r_leak_ctr   <= '0;
                        r_leak_valid <= 1'b1;
                        r_leak_bits  <= w_cap_fill[SHIFT_W-1:0];
                    end else begin
                        r_cap_ctr <= r_cap_ctr + 1'b1;
                    end
                end
                ST_LEAK: begin
                    r_cap <= w_cap_shift;
                    if (r_leak_ctr == C_LEAK_LAST) begin
                        r_state      <= ST_DONE;
                        r_leak_valid <= 1'b0;
                        r_leak_bits  <= '0;
                    end else begin
                        r_leak_ctr  <= r_leak_ctr + 1'b1;
                        r_leak_bits <= w_cap_shift[SHIFT_W-1:0];
                    end
                end
                ST_DONE: begin
                    r_cap <= '0;
                    if (!ONE_SHOT) begin
                        r_state <= ST_IDLE;
                        r_busy  <= 1'b0;
                    end
                end
                default: begin
                    r_state      <= ST_IDLE;
                    r_leak_valid <= 1'b0;
                    r_leak_bits  <= '0;
                    r_busy       <= 1'b0;
                end
            endcase
        end
    end

    assign leak_bits  = r_leak_bits;
    assign leak_valid = r_leak_valid;
    assign busy       = r_busy;

endmodule
`default_nettype wire

// File: tb/tb_trojan_leak_param.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : tb_trojan_leak_param                                            |
// | Brief    : Bench for trojan_leak_param with a timeline reference model.    |
// | Revision : 1.0                                                             |
// +----------------------------------------------------------------------------+
module tb_trojan_leak_param;

    localparam logic [63:0] TRIG = 64'h0000_0000_0044_ab93;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic [63:0] data0 = '0;
    logic [63:0] data1 = '0;
    logic [47:0] data2 = '0;
    logic [1:0]  lb0, lb1;
    logic [2:0]  lb2;
    logic        lv0, lv1, lv2, busy0, busy1, busy2;
    logic [4:0]  obs0, obs1, obs2;

    int checks = 0;
    int errors = 0;
    int n = 0;

    // Per-instance configuration: 0 default, 1 one-shot, 2 48-bit/5-bit variant.
    int c_nw    [3] = '{4, 4, 5};
    int c_cap   [3] = '{4, 4, 3};
    int c_sw    [3] = '{2, 2, 3};
    int c_tw    [3] = '{64, 64, 32};
    int c_os    [3] = '{0, 1, 0};
    int c_slots [3] = '{16, 16, 9};
    int c_selw  [3] = '{4, 4, 4};

    int          m_t    [3];
    int          m_done [3];
    int          m_sel  [3];
    logic [63:0] m_prev [3];
    logic [63:0] m_cap  [3];
    logic [4:0]  exp_out[3];

    assign obs0 = {busy0, lv0, 1'b0, lb0};
    assign obs1 = {busy1, lv1, 1'b0, lb1};
    assign obs2 = {busy2, lv2, lb2};

    trojan_leak_param u_dut (
        .clk(clk), .rst_all_n(rst_n), .data(data0),
        .leak_bits(lb0), .leak_valid(lv0), .busy(busy0)
    );

    trojan_leak_param #(.ONE_SHOT(1'b1)) u_dut_os (
        .clk(clk), .rst_all_n(rst_n), .data(data1),
        .leak_bits(lb1), .leak_valid(lv1), .busy(busy1)
    );

    trojan_leak_param #(
        .DATA_W(48), .NIB_W(5), .CAPTURES(3), .SHIFT_W(3), .TRIG_W(32)
    ) u_dut_w (
        .clk(clk), .rst_all_n(rst_n), .data(data2),
        .leak_bits(lb2), .leak_valid(lv2), .busy(busy2)
    );

    always #5 clk = ~clk;

    function automatic logic [63:0] rand64();
        return {$urandom, $urandom};
    endfunction

    function automatic logic [47:0] rand48();
        logic [63:0] r;
        r = {$urandom, $urandom};
        return r[47:0];
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 3; i++) begin
            m_t[i] = -1; m_done[i] = -10; m_sel[i] = 0;
            m_prev[i] = '0; m_cap[i] = '0; exp_out[i] = '0;
        end
    endtask

    // Timeline model: a trigger accepted at edge t captures on edges t+1..t+C,
    // leaks on observations t+C..t+C+L-1 and stays busy through t+C+L.
    task automatic model_step(input int id, input logic [63:0] d);
        int          len;
        logic [63:0] tmask, nmask, smask, slice;
        bit          valid;
        len   = c_nw[id] * c_cap[id] / c_sw[id];
        tmask = (c_tw[id] == 64) ? {64{1'b1}} : ((64'd1 << c_tw[id]) - 64'd1);
        nmask = (64'd1 << c_nw[id]) - 64'd1;
        smask = (64'd1 << c_sw[id]) - 64'd1;
        if (((d & tmask) == (TRIG & tmask)) && (n >= m_done[id] + 2) &&
            !(c_os[id] == 1 && m_t[id] >= 0)) begin
            m_t[id]    = n;
            m_done[id] = n + c_cap[id] + len;
            m_cap[id]  = '0;
            m_sel[id]  = int'(m_prev[id] & ((64'd1 << c_selw[id]) - 64'd1));
            if (m_sel[id] > c_slots[id] - 1) m_sel[id] = c_slots[id] - 1;
        end else if (m_t[id] >= 0 && n > m_t[id] && n <= m_t[id] + c_cap[id]) begin
            slice = (d >> (m_sel[id] * c_nw[id])) & nmask;
            m_cap[id] = m_cap[id] | (slice << (c_nw[id] * (n - m_t[id] - 1)));
        end
        m_prev[id] = d;
        valid = (m_t[id] >= 0) && (n >= m_t[id] + c_cap[id]) && (n < m_t[id] + c_cap[id] + len);
        exp_out[id][4]   = (m_t[id] >= 0) && (n >= m_t[id]) && ((n <= m_done[id]) || c_os[id] == 1);
        exp_out[id][3]   = valid;
        exp_out[id][2:0] = valid ? 3'((m_cap[id] >> (c_sw[id] * (n - m_t[id] - c_cap[id]))) & smask) : 3'd0;
    endtask

    task automatic tick();
        @(posedge clk);
        n++;
        model_step(0, data0);
        model_step(1, data1);
        model_step(2, {16'h0, data2});
        #1;
    endtask

    task automatic test_reset();
        #1 rst_n = 1'b0;
        model_reset();
        repeat (2) @(negedge clk);
        checks++;
        if (obs0 !== 5'd0) begin errors++; $display("FAIL reset_dut0 got %h exp 00", obs0); end
        checks++;
        if (obs1 !== 5'd0) begin errors++; $display("FAIL reset_dut1 got %h exp 00", obs1); end
        checks++;
        if (obs2 !== 5'd0) begin errors++; $display("FAIL reset_dut2 got %h exp 00", obs2); end
        rst_n = 1'b1;
        repeat (3) begin
            tick();
            checks++;
            if (obs0 !== exp_out[0]) begin errors++; $display("FAIL reset_idle got %h exp %h", obs0, exp_out[0]); end
        end
    endtask

    task automatic test_basic();
        logic [15:0] pat = 16'hDCBA;
        logic [15:0] seq = {2'd3, 2'd1, 2'd3, 2'd0, 2'd2, 2'd3, 2'd2, 2'd2};
        logic [63:0] w;
        int k = 0, nbusy = 0, first = -1;
        for (int s = 0; s < 20; s++) begin
            if (s == 0) begin w = rand64(); w[3:0] = 4'd5; end
            else if (s == 1) w = TRIG;
            else if (s <= 5) begin w = rand64(); w[23:20] = pat[4*(s-2) +: 4]; end
            else w = '0;
            data0 = w;
            tick();
            checks++;
            if (obs0 !== exp_out[0]) begin errors++; $display("FAIL basic_model step=%0d got %h exp %h", s, obs0, exp_out[0]); end
            if (s >= 1 && busy0 === 1'b1) nbusy++;
            if (lv0 === 1'b1) begin
                if (first < 0) first = s - 1;
                checks++;
                if (k > 7 || lb0 !== seq[2*k +: 2]) begin
                    errors++; $display("FAIL basic_leak_bits beat=%0d got %0d", k, lb0);
                end
                k++;
            end
        end
        checks++;
        if (k != 8) begin errors++; $display("FAIL basic_leak_len got %0d exp 8", k); end
        checks++;
        if (nbusy != 13) begin errors++; $display("FAIL basic_busy_len got %0d exp 13", nbusy); end
        checks++;
        if (first != 4) begin errors++; $display("FAIL basic_first_valid got %0d exp 4", first); end
    endtask

    task automatic test_retrigger();
        logic [63:0] w;
        int k = 0, nbusy = 0;
        for (int s = 0; s < 20; s++) begin
            if (s == 0) begin w = rand64(); w[3:0] = 4'd5; end
            else if (s == 1 || s == 3) w = TRIG;
            else if (s <= 5) w = rand64();
            else w = '0;
            data0 = w;
            tick();
            checks++;
            if (obs0 !== exp_out[0]) begin errors++; $display("FAIL retrig_model step=%0d got %h exp %h", s, obs0, exp_out[0]); end
            if (s >= 1 && busy0 === 1'b1) nbusy++;
            if (lv0 === 1'b1) k++;
        end
        checks++;
        if (k != 8 || nbusy != 13) begin
            errors++; $display("FAIL retrig_lengths got valid=%0d busy=%0d exp 8/13", k, nbusy);
        end
    endtask

    task automatic test_back_to_back();
        int k = 0, nidle = 0;
        for (int s = 0; s < 35; s++) begin
            if (s == 0) data0 = rand64();
            else if (s == 1 || s == 14 || s == 15) data0 = TRIG;
            else if ((s >= 2 && s <= 5) || (s >= 16 && s <= 19)) data0 = rand64();
            else data0 = '0;
            tick();
            checks++;
            if (obs0 !== exp_out[0]) begin errors++; $display("FAIL b2b_model step=%0d got %h exp %h", s, obs0, exp_out[0]); end
            if (lv0 === 1'b1) k++;
            if (s >= 1 && s <= 27 && busy0 !== 1'b1) nidle++;
        end
        checks++;
        if (k != 16 || nidle != 1) begin
            errors++; $display("FAIL b2b_lengths got valid=%0d idle=%0d exp 16/1", k, nidle);
        end
    endtask

    task automatic test_near_miss();
        for (int s = 0; s < 8; s++) begin
            if (s[0] == 1'b0) begin
                data0 = TRIG ^ 64'd1;
                data2 = 48'hab93_0000_0000;
            end else begin
                data0 = TRIG | (64'd1 << 63);
                data2 = {16'h44ab, 32'h0044_ab92};
            end
            tick();
            checks++;
            if (busy0 !== 1'b0 || obs0 !== exp_out[0]) begin
                errors++; $display("FAIL near_miss_dut0 step=%0d got %h exp %h", s, obs0, exp_out[0]);
            end
            checks++;
            if (busy2 !== 1'b0 || obs2 !== exp_out[2]) begin
                errors++; $display("FAIL near_miss_dut2 step=%0d got %h exp %h", s, obs2, exp_out[2]);
            end
        end
        data0 = '0; data2 = '0;
    endtask

    task automatic test_clamp();
        logic [47:0] w;
        logic [14:0] want = '0;
        logic [14:0] got = '0;
        int k = 0;
        for (int s = 0; s < 14; s++) begin
            if (s == 0) begin w = rand48(); w[3:0] = 4'd15; end
            else if (s == 1) w = {rand48() >> 32, 32'h0044_ab93};
            else if (s <= 4) begin w = rand48(); want = want | (15'(w[44:40]) << (5*(s-2))); end
            else w = '0;
            data2 = w;
            tick();
            checks++;
            if (obs2 !== exp_out[2]) begin errors++; $display("FAIL clamp_model step=%0d got %h exp %h", s, obs2, exp_out[2]); end
            if (lv2 === 1'b1) begin
                if (k < 5) got = got | (15'(lb2) << (3*k));
                k++;
            end
        end
        checks++;
        if (k != 5) begin errors++; $display("FAIL clamp_leak_len got %0d exp 5", k); end
        checks++;
        if (got !== want) begin errors++; $display("FAIL clamp_bits got %h exp %h", got, want); end
    endtask

    task automatic test_one_shot();
        int k = 0;
        for (int s = 0; s < 41; s++) begin
            if (s == 1 || s == 21) data1 = TRIG;
            else if (s <= 5 || s >= 22) data1 = rand64();
            else data1 = '0;
            tick();
            checks++;
            if (obs1 !== exp_out[1]) begin errors++; $display("FAIL oneshot_model step=%0d got %h exp %h", s, obs1, exp_out[1]); end
            if (lv1 === 1'b1) k++;
        end
        checks++;
        if (k != 8) begin errors++; $display("FAIL oneshot_leak_len got %0d exp 8", k); end
        checks++;
        if (busy1 !== 1'b1) begin errors++; $display("FAIL oneshot_busy_held got %b exp 1", busy1); end
        data1 = '0;
    endtask

    task automatic test_reset_mid();
        int k = 0;
        for (int s = 0; s < 8; s++) begin
            if (s == 0) begin data0 = rand64(); data0[3:0] = 4'd5; end
            else if (s == 1) data0 = TRIG;
            else if (s <= 5) data0 = rand64();
            else data0 = '0;
            tick();
            checks++;
            if (obs0 !== exp_out[0]) begin errors++; $display("FAIL rstmid_model step=%0d got %h exp %h", s, obs0, exp_out[0]); end
        end
        #3 rst_n = 1'b0;
        #1;
        checks++;
        if (obs0 !== 5'd0) begin errors++; $display("FAIL rstmid_async_dut0 got %h exp 00", obs0); end
        checks++;
        if (obs1 !== 5'd0) begin errors++; $display("FAIL rstmid_async_dut1 got %h exp 00", obs1); end
        model_reset();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        for (int s = 0; s < 15; s++) begin
            tick();
            checks++;
            if (obs0 !== exp_out[0]) begin errors++; $display("FAIL rstmid_after step=%0d got %h exp %h", s, obs0, exp_out[0]); end
            if (lv0 === 1'b1) k++;
        end
        checks++;
        if (k != 0) begin errors++; $display("FAIL rstmid_no_valid got %0d exp 0", k); end
    endtask

    task automatic test_random();
        for (int s = 0; s < 300; s++) begin
            data0 = ($urandom_range(0, 7) == 0) ? TRIG : rand64();
            data2 = ($urandom_range(0, 7) == 0) ? {rand48() >> 32, 32'h0044_ab93} : rand48();
            tick();
            checks++;
            if (obs0 !== exp_out[0]) begin errors++; $display("FAIL random_dut0 step=%0d got %h exp %h", s, obs0, exp_out[0]); end
            checks++;
            if (obs2 !== exp_out[2]) begin errors++; $display("FAIL random_dut2 step=%0d got %h exp %h", s, obs2, exp_out[2]); end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_retrigger();
        test_back_to_back();
        test_near_miss();
        test_clamp();
        test_one_shot();
        test_reset_mid();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
